// File: rtl/pak_dsp_seq_if.sv
// pak_dsp_seq_if: bus bundle between the pak_dsp_seq sequencer and its surroundings.
//   cfg_*  : coefficient configuration stream (valid/ready) into the sequencer
//   mem_*  : DSP coefficient memory port driven by the sequencer (1-cycle read latency)
//   src_*  : upstream sample stream into the sequencer
//   dsp_*  : gated sample stream out to the DSP
// Modports: master = sequencer side, slave = environment (source, DSP, memory) side.
interface pak_dsp_seq_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned N           = 8
);
  localparam int unsigned ADDR_WIDTH = $clog2(N);

  logic [COEFF_WIDTH-1:0] cfg_coeff_in;
  logic                   cfg_valid_in;
  logic                   cfg_ready_out;

  logic [ADDR_WIDTH-1:0]  mem_addr_out;
  logic                   mem_write_en_out;
  logic [COEFF_WIDTH-1:0] mem_wdata_out;
  logic [COEFF_WIDTH-1:0] mem_rdata_in;

  logic [DATA_WIDTH-1:0]  src_data_in;
  logic                   src_valid_in;
  logic                   src_ready_out;

  logic [DATA_WIDTH-1:0]  dsp_data_out;
  logic                   dsp_valid_out;
  logic                   dsp_ready_in;

  modport master (
    input  cfg_coeff_in, cfg_valid_in, mem_rdata_in, src_data_in, src_valid_in, dsp_ready_in,
    output cfg_ready_out, mem_addr_out, mem_write_en_out, mem_wdata_out, src_ready_out,
           dsp_data_out, dsp_valid_out
  );

  modport slave (
    output cfg_coeff_in, cfg_valid_in, mem_rdata_in, src_data_in, src_valid_in, dsp_ready_in,
    input  cfg_ready_out, mem_addr_out, mem_write_en_out, mem_wdata_out, src_ready_out,
           dsp_data_out, dsp_valid_out
  );
endinterface

// File: rtl/pak_dsp_seq.sv
// pak_dsp_seq: run-time sequencer for the pak_dsp datapath.
// Loads N coefficients into the DSP coefficient memory from the cfg stream, then passes the
// sample stream through to the DSP in whole N-sample frames until the frame target is reached
// or a stop request lands on a frame boundary.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start_in          : start pulse (IDLE only); frames_in latched as the frame target (0 = endless)
//   stop_in           : stop request, honoured at the next frame boundary (RUN only)
//   busy_out          : state is not IDLE
//   done_out          : 1-cycle pulse on the final handshake / stop cycle / readback failure
//   frame_count_out   : frames completed in the current or last run (saturating)
//   err_out           : sticky coefficient readback mismatch
//   bus               : cfg / mem / src / dsp signals (pak_dsp_seq_if master side)
// Build option: define PAK_DSP_SEQ_READBACK_EN to add the VERIFY state, which reads the
// memory back after loading and compares XOR checksums; otherwise err_out is tied to 0.
module pak_dsp_seq #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned N           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic [15:0] frames_in,
  input  logic        stop_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [15:0] frame_count_out,
  output logic        err_out,
  pak_dsp_seq_if.master bus
);

  localparam int unsigned ADDR_WIDTH = $clog2(N);
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StRun} state_e;

  state_e                state_q, state_d;
  logic [15:0]           target_q, target_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [ADDR_WIDTH-1:0] beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] load_cnt_q, load_cnt_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  done;
  logic                  src_hs;
  logic                  target_hit;
  logic [15:0]           frame_cnt_inc;

`ifdef PAK_DSP_SEQ_READBACK_EN
  logic [COEFF_WIDTH-1:0] wr_sum_q, wr_sum_d;
  logic [COEFF_WIDTH-1:0] rd_sum_q, rd_sum_d;
  logic [ADDR_WIDTH:0]    vcnt_q, vcnt_d;
  logic                   err_q, err_d;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata_in;
`endif

  assign src_hs        = (state_q == StRun) && bus.src_valid_in && bus.dsp_ready_in;
  assign target_hit    = (target_q != 16'd0) && ((frame_cnt_q + 16'd1) == target_q);
  assign frame_cnt_inc = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    frame_cnt_d = frame_cnt_q;
    beat_d      = beat_q;
    load_cnt_d  = load_cnt_q;
    stop_pend_d = stop_pend_q;
    done        = 1'b0;
`ifdef PAK_DSP_SEQ_READBACK_EN
    wr_sum_d    = wr_sum_q;
    rd_sum_d    = rd_sum_q;
    vcnt_d      = vcnt_q;
    err_d       = err_q;
`endif

    bus.cfg_ready_out    = 1'b0;
    bus.mem_write_en_out = 1'b0;
    bus.mem_addr_out     = '0;
    bus.mem_wdata_out    = '0;
    bus.src_ready_out    = 1'b0;
    bus.dsp_valid_out    = 1'b0;
    bus.dsp_data_out     = '0;

    case (state_q)
      StIdle: begin
        if (start_in) begin
          target_d    = frames_in;
          frame_cnt_d = 16'd0;
          beat_d      = '0;
          load_cnt_d  = '0;
          stop_pend_d = 1'b0;
`ifdef PAK_DSP_SEQ_READBACK_EN
          err_d       = 1'b0;
          wr_sum_d    = '0;
`endif
          state_d     = StLoad;
        end
      end

      StLoad: begin
        bus.cfg_ready_out = 1'b1;
        bus.mem_addr_out  = load_cnt_q;
        if (bus.cfg_valid_in) begin
          bus.mem_write_en_out = 1'b1;
          bus.mem_wdata_out    = bus.cfg_coeff_in;
          load_cnt_d           = load_cnt_q + 1'b1;
`ifdef PAK_DSP_SEQ_READBACK_EN
          wr_sum_d             = wr_sum_q ^ bus.cfg_coeff_in;
`endif
          if (load_cnt_q == LastIdx) begin
            load_cnt_d = '0;
`ifdef PAK_DSP_SEQ_READBACK_EN
            vcnt_d     = '0;
            rd_sum_d   = '0;
            state_d    = StVerify;
`else
            state_d    = StRun;
`endif
          end
        end
      end

`ifdef PAK_DSP_SEQ_READBACK_EN
      StVerify: begin
        // Address v issued in cycle v, its data folded in cycle v+1; cycle N only folds.
        if (vcnt_q < (ADDR_WIDTH+1)'(N)) begin
          bus.mem_addr_out = vcnt_q[ADDR_WIDTH-1:0];
        end
        vcnt_d = vcnt_q + 1'b1;
        if (vcnt_q != '0) begin
          rd_sum_d = rd_sum_q ^ bus.mem_rdata_in;
        end
        if (vcnt_q == (ADDR_WIDTH+1)'(N)) begin
          if ((rd_sum_q ^ bus.mem_rdata_in) == wr_sum_q) begin
            state_d = StRun;
          end else begin
            err_d   = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
          end
        end
      end
`endif

      StRun: begin
        bus.dsp_data_out  = bus.src_data_in;
        bus.dsp_valid_out = bus.src_valid_in;
        bus.src_ready_out = bus.dsp_ready_in;
        if (src_hs) begin
          if (beat_q == LastIdx) begin
            beat_d      = '0;
            frame_cnt_d = frame_cnt_inc;
            // A stop raised on the closing beat still ends this frame.
            if (target_hit || stop_pend_q || stop_in) begin
              done    = 1'b1;
              state_d = StIdle;
            end
          end else begin
            beat_d = beat_q + 1'b1;
            if (stop_in) begin
              stop_pend_d = 1'b1;
            end
          end
        end else if (stop_in) begin
          // Idle at a frame boundary: nothing in flight, so stop now.
          if (beat_q == '0) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            stop_pend_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      target_q    <= 16'd0;
      frame_cnt_q <= 16'd0;
      beat_q      <= '0;
      load_cnt_q  <= '0;
      stop_pend_q <= 1'b0;
`ifdef PAK_DSP_SEQ_READBACK_EN
      wr_sum_q    <= '0;
      rd_sum_q    <= '0;
      vcnt_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      frame_cnt_q <= frame_cnt_d;
      beat_q      <= beat_d;
      load_cnt_q  <= load_cnt_d;
      stop_pend_q <= stop_pend_d;
`ifdef PAK_DSP_SEQ_READBACK_EN
      wr_sum_q    <= wr_sum_d;
      rd_sum_q    <= rd_sum_d;
      vcnt_q      <= vcnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign busy_out        = (state_q != StIdle);
  // A reset cycle never reports completion.
  assign done_out        = done && !rst;
  assign frame_count_out = frame_cnt_q;
`ifdef PAK_DSP_SEQ_READBACK_EN
  assign err_out         = err_q;
`else
  assign err_out         = 1'b0;
`endif

endmodule

// File: tb/tb_pak_dsp_seq.sv
// tb_pak_dsp_seq: scoreboard bench for pak_dsp_seq. Stimulus pushes expected memory writes,
// forwarded samples and run completions into queues; a negedge monitor pops and compares
// whenever the DUT shows a write strobe, a DSP-side handshake or a done pulse.
module tb_pak_dsp_seq;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int N  = 8;
  localparam int AW = $clog2(N);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic [15:0] frames_in = 16'd0;
  logic        stop_in = 1'b0;
  logic        busy_out, done_out, err_out;
  logic [15:0] frame_count_out;

  pak_dsp_seq_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N(N)) bus ();

  pak_dsp_seq #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .N(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_in        (start_in),
    .frames_in       (frames_in),
    .stop_in         (stop_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .frame_count_out (frame_count_out),
    .err_out         (err_out),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  // DSP coefficient memory model; 'corrupt' flips bit 0 of address 4 on read.
  logic [CW-1:0] mem_model [N];
  bit            corrupt = 1'b0;
  always @(posedge clk) begin
    if (bus.mem_write_en_out) mem_model[bus.mem_addr_out] <= bus.mem_wdata_out;
    bus.mem_rdata_in <= mem_model[bus.mem_addr_out] ^
                        {{(CW-1){1'b0}}, corrupt && (bus.mem_addr_out == AW'(4))};
  end

  typedef struct {logic [AW-1:0] addr; logic [CW-1:0] data;} wr_t;
  typedef struct {logic [15:0] fc; logic err;} done_t;

  wr_t         wr_q[$];
  logic [DW-1:0] samp_q[$];
  done_t       done_q[$];
  int          vec  = 0;
  int          miss = 0;
  done_t       pend;
  bit          chk_after_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (chk_after_done) begin
      chk_after_done = 1'b0;
      chk("done_frame_count", frame_count_out, pend.fc);
      chk("done_err", err_out, pend.err);
      chk("done_idle", busy_out, 0);
    end
    if (!rst) begin
      if (bus.mem_write_en_out) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("write_addr", bus.mem_addr_out, w.addr);
          chk("write_data", bus.mem_wdata_out, w.data);
        end
      end
      if (bus.dsp_valid_out && bus.dsp_ready_in) begin
        if (samp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("beat_data", bus.dsp_data_out, samp_q.pop_front());
      end
      if (done_out) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          pend = done_q.pop_front();
          chk_after_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] f);
    start_in = 1'b1;
    frames_in = f;
    @(negedge clk);
    tick();
    start_in = 1'b0;
    @(negedge clk);
    chk("start_busy", busy_out, 1);
    chk("start_cfg_ready", bus.cfg_ready_out, 1);
    tick();
  endtask

  // Push 'count' coefficients (sequential 1..N or random), optionally with random gaps.
  task automatic load(input bit seq, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      logic [CW-1:0] c;
      wr_t w;
      c = seq ? CW'(i + 1) : CW'($urandom);
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          bus.cfg_valid_in = 1'b0;
          @(negedge clk);
          tick();
        end
      end
      bus.cfg_valid_in = 1'b1;
      bus.cfg_coeff_in = c;
      w.addr = AW'(i);
      w.data = c;
      wr_q.push_back(w);
      @(negedge clk);
      tick();
    end
    bus.cfg_valid_in = 1'b0;
  endtask

  task automatic after_load();
`ifdef PAK_DSP_SEQ_READBACK_EN
    bus.src_valid_in = 1'b0;
    repeat (N + 1) tick();
`endif
    bus.src_valid_in = 1'b0;
    bus.dsp_ready_in = 1'b1;
    @(negedge clk);
    chk("run_entered", bus.src_ready_out, 1);
    tick();
  endtask

  task automatic run_stream(input int nsamp, input bit toggle, input int stop_after,
                            input int start_at, input bit expect_done, output int acc);
    logic [DW-1:0] src_q[$];
    bit stopped, started, fin, d;
    for (int i = 0; i < nsamp; i++) begin
      logic [DW-1:0] s;
      s = DW'($urandom);
      src_q.push_back(s);
      samp_q.push_back(s);
    end
    acc = 0;
    stopped = 1'b0;
    started = 1'b0;
    fin = 1'b0;
    bus.dsp_ready_in = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (src_q.size() > 0) begin
        bus.src_valid_in = toggle ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.src_data_in = src_q[0];
      end else begin
        bus.src_valid_in = 1'b0;
      end
      bus.dsp_ready_in = toggle ? ~bus.dsp_ready_in : ($urandom_range(0, 2) != 0);
      stop_in = (stop_after >= 0) && !stopped && (acc == stop_after);
      if (stop_in) stopped = 1'b1;
      start_in = (start_at >= 0) && !started && (acc == start_at);
      frames_in = 16'd5;
      if (start_in) started = 1'b1;
      @(negedge clk);
      if (start_in) begin
        chk("start_ignored_frame_count", frame_count_out, acc / N);
        chk("start_ignored_busy", busy_out, 1);
      end
      if (bus.src_valid_in && bus.src_ready_out) begin
        void'(src_q.pop_front());
        acc++;
      end
      d = done_out;
      tick();
      stop_in = 1'b0;
      start_in = 1'b0;
      if (d || (!expect_done && src_q.size() == 0)) fin = 1'b1;
    end
    if (!fin) chk("run_timeout", 1, 0);
    bus.src_valid_in = 1'b0;
  endtask

  task automatic post_run_idle();
    bus.src_valid_in = 1'b1;
    bus.src_data_in = 16'hDEAD;
    bus.dsp_ready_in = 1'b1;
    @(negedge clk);
    chk("idle_src_ready", bus.src_ready_out, 0);
    chk("idle_dsp_valid", bus.dsp_valid_out, 0);
    tick();
    bus.src_valid_in = 1'b0;
    tick();
  endtask

  function automatic done_t mk_done(input int fc, input bit err);
    done_t t;
    t.fc = 16'(fc);
    t.err = err;
    return t;
  endfunction

  initial begin
    int acc;
    bus.cfg_valid_in = 1'b0;
    bus.cfg_coeff_in = '0;
    bus.src_valid_in = 1'b0;
    bus.src_data_in = '0;
    bus.dsp_ready_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    bus.dsp_ready_in = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", bus.cfg_ready_out, 0);
    chk("rst_mem_we", bus.mem_write_en_out, 0);
    chk("rst_mem_addr", bus.mem_addr_out, 0);
    chk("rst_mem_wdata", bus.mem_wdata_out, 0);
    chk("rst_dsp_valid", bus.dsp_valid_out, 0);
    chk("rst_src_ready", bus.src_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_frame_count", frame_count_out, 0);
    chk("rst_err", err_out, 0);
    tick();

    // Load path + 2-frame run with toggling ready; a start pulse mid-run must be ignored.
    do_start(16'd2);
    load(1'b1, N, 1'b0);
    after_load();
    done_q.push_back(mk_done(2, 1'b0));
    run_stream(2 * N, 1'b1, -1, 10, 1'b1, acc);
    chk("frames2_forwarded", acc, 2 * N);
    post_run_idle();

    // Endless run, stop raised at beat 3 of the first frame: frame completes.
    do_start(16'd0);
    load(1'b0, N, 1'b1);
    after_load();
    done_q.push_back(mk_done(3 / N + 1, 1'b0));
    run_stream(N, 1'b0, 3, -1, 1'b1, acc);
    chk("stop_mid_forwarded", acc, N);
    post_run_idle();

    // Endless run, one full frame, then stop at a boundary with no handshake.
    do_start(16'd0);
    load(1'b0, N, 1'b1);
    after_load();
    run_stream(N, 1'b0, -1, -1, 1'b0, acc);
    chk("stop_b0_forwarded", acc, N);
    done_q.push_back(mk_done(acc / N, 1'b0));
    stop_in = 1'b1;
    bus.src_valid_in = 1'b0;
    @(negedge clk);
    chk("stop_b0_done", done_out, 1);
    tick();
    stop_in = 1'b0;
    post_run_idle();

    // Reset in the middle of LOAD.
    do_start(16'd3);
    load(1'b0, 5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    bus.cfg_valid_in = 1'b1;
    bus.cfg_coeff_in = 16'hBEEF;
    @(negedge clk);
    chk("midrst_cfg_ready", bus.cfg_ready_out, 0);
    chk("midrst_mem_we", bus.mem_write_en_out, 0);
    chk("midrst_mem_addr", bus.mem_addr_out, 0);
    chk("midrst_mem_wdata", bus.mem_wdata_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_done", done_out, 0);
    chk("midrst_frame_count", frame_count_out, 0);
    chk("midrst_err", err_out, 0);
    tick();
    bus.cfg_valid_in = 1'b0;
    do_start(16'd1);
    load(1'b0, N, 1'b1);
    after_load();
    done_q.push_back(mk_done(1, 1'b0));
    run_stream(N, 1'b0, -1, -1, 1'b1, acc);
    chk("after_rst_forwarded", acc, N);
    post_run_idle();

`ifdef PAK_DSP_SEQ_READBACK_EN
    // Corrupted readback: err set, done after N+1 VERIFY cycles, no beats leak.
    begin
      int k;
      bit seen;
      corrupt = 1'b1;
      do_start(16'd1);
      load(1'b0, N, 1'b0);
      done_q.push_back(mk_done(0, 1'b1));
      bus.src_valid_in = 1'b1;
      bus.src_data_in = 16'h5A5A;
      bus.dsp_ready_in = 1'b1;
      seen = 1'b0;
      k = 0;
      for (int c = 1; c <= N + 5 && !seen; c++) begin
        @(negedge clk);
        if (done_out) begin
          seen = 1'b1;
          k = c;
        end
        tick();
      end
      chk("verify_len", k, N + 1);
      bus.src_valid_in = 1'b0;
      tick();
      corrupt = 1'b0;
      do_start(16'd1);
      chk("err_cleared", err_out, 0);
      load(1'b0, N, 1'b1);
      after_load();
      done_q.push_back(mk_done(1, 1'b0));
      run_stream(N, 1'b0, -1, -1, 1'b1, acc);
      chk("clean_verify_forwarded", acc, N);
      post_run_idle();
    end
`endif

    chk("left_writes", wr_q.size(), 0);
    chk("left_samples", samp_q.size(), 0);
    chk("left_dones", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/pak_dsp_seq.md
# pak_dsp_seq

Run-time sequencer for the `pak_dsp` datapath. It loads N coefficients into the DSP's coefficient memory from a configuration stream. It then gates the sample stream into the DSP in whole N-sample frames, and stops after a programmed frame count or at the first frame boundary after a stop request. It sits between the upstream sample source and the DSP's `src_*` ports, and it owns the DSP's memory write port.

## Interface
- `DATA_WIDTH`, 16: sample width on the gated stream.
- `COEFF_WIDTH`, 16: coefficient width.
- `N`, 8: taps, which is also the frame length in samples. Must be at least 2.
- `ADDR_WIDTH`, `$clog2(N)`: coefficient memory address width. This is a derived localparam.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_in`  in  1  start pulse; sampled only in IDLE.
- `frames_in`  in  16  frame target, latched on start; 0 means run until stopped.
- `stop_in`  in  1  stop request; takes effect at the next frame boundary.
- `cfg_coeff_in`  in  COEFF_WIDTH  coefficient data.
- `cfg_valid_in`  in  1  coefficient valid.
- `cfg_ready_out`  out  1  coefficient ready.
- `mem_addr_out`  out  ADDR_WIDTH  DSP coefficient address.
- `mem_write_en_out`  out  1  DSP coefficient write strobe.
- `mem_wdata_out`  out  COEFF_WIDTH  DSP coefficient write data.
- `mem_rdata_in`  in  COEFF_WIDTH  DSP coefficient read data; 1-cycle read latency.
- `src_data_in`, `src_valid_in`, `src_ready_out`  in/in/out  DATA_WIDTH/1/1  upstream sample stream.
- `dsp_data_out`, `dsp_valid_out`, `dsp_ready_in`  out/out/in  DATA_WIDTH/1/1  gated stream to the DSP `src_*` ports.
- `busy_out`  out  1  high whenever the state is not IDLE.
- `done_out`  out  1  1-cycle pulse when a run ends.
- `frame_count_out`  out  16  frames completed in the current or last run.
- `err_out`  out  1  sticky readback-mismatch flag.

## Operation
The sequencer is a state machine with states IDLE, LOAD, VERIFY and RUN.

- **IDLE**
  - A `start_in` pulse latches `frames_in` into `target` and clears `frame_count_out`, the beat counter, `stop_pend` and `err_out`.
  - The state then moves to LOAD.
- **LOAD**
  - `cfg_ready_out` is held at 1.
  - On each handshake (`cfg_valid_in & cfg_ready_out`), the memory write is combinational: `mem_write_en_out` is 1, `mem_addr_out` is `load_cnt` and `mem_wdata_out` is `cfg_coeff_in`.
  - `load_cnt` increments after each handshake.
  - The handshake at address N-1 moves the state to VERIFY when PAK_DSP_SEQ_READBACK_EN is defined, otherwise to RUN.
  - Gaps in `cfg_valid_in` stall LOAD indefinitely.
- **VERIFY** (exists only when the macro is defined)
  - The block reads addresses 0 to N-1 on consecutive cycles and XOR-folds `mem_rdata_in`, taken one cycle after each address, into `rd_sum`.
  - During LOAD, the written coefficients are folded into `wr_sum` the same way.
  - VERIFY lasts N+1 cycles.
  - If the sums match, the state moves to RUN.
  - If they mismatch, `err_out` is set to 1, `done_out` pulses and the state moves to IDLE.
- **RUN**
  - The stream is a combinational pass-through: `dsp_data_out = src_data_in`, `dsp_valid_out = src_valid_in` and `src_ready_out = dsp_ready_in`.
  - Each stream handshake increments `beat` (range 0 to N-1).
  - When `beat` is N-1 and a handshake occurs, `beat` wraps to 0 and `frame_count_out` increments.
  - The run ends when `frame_count_out + 1 == target` (with `target` nonzero), or when `stop_pend` is set at that frame completion. On ending, `done_out` pulses and the state moves to IDLE.
  - When `stop_in` is asserted at a frame boundary (`beat` is 0) with no handshake that cycle, the run ends immediately: `done_out` pulses and the state moves to IDLE. Otherwise `stop_pend` is set.
- Outside RUN, `dsp_valid_out` and `src_ready_out` are 0, so the DSP never sees a partial frame.
- `start_in` is ignored outside IDLE. `stop_in` is ignored outside RUN.
- `frame_count_out` saturates at 0xFFFF when `target` is 0.

## Timing
- **Reset values:** state IDLE; `cfg_ready_out`, `mem_write_en_out`, `mem_addr_out`, `mem_wdata_out`, `dsp_valid_out`, `src_ready_out`, `busy_out`, `done_out`, `frame_count_out` and `err_out` are all 0.
- **Start to LOAD:** `start_in` at edge k gives `busy_out` = 1 and `cfg_ready_out` = 1 from cycle k+1.
- **Write latency:** 0 cycles. The write strobe is in the same cycle as the configuration handshake.
- **First sample:** RUN is entered in the cycle after the write to address N-1 (without readback), so the first sample can be accepted then.
- **Readback delay:** with readback enabled, RUN is entered N+1 cycles later.
- **done pulse:** `done_out` is high for exactly one cycle, aligned with the final handshake (or with the stop cycle). State is IDLE in the next cycle, and `start_in` can be accepted there.
- **Reset mid-operation:**
  - Returns to IDLE with no `done_out` pulse.
  - Memory contents are not rewritten.
  - A partial frame already forwarded is abandoned.

## Configuration
- **`PAK_DSP_SEQ_READBACK_EN`**
  - **Defined:** the VERIFY state, the XOR checksums and the `err_out` logic are compiled in.
  - **Undefined:** LOAD goes directly to RUN, `mem_addr_out` never issues reads, and `err_out` is tied to 0.

## Test plan
- **Load path:** reset, start with `frames_in` = 2, then push coefficients 0x0001 to 0x0008 back-to-back. Expect 8 write strobes with address equal to index and data equal to index+1, then the state reaches RUN.
- **Frame-count run:** feed 16 samples with `dsp_ready_in` toggling every cycle. Expect exactly 16 samples forwarded, `frame_count_out` = 2, one `done_out` pulse on the 16th handshake, and `src_ready_out` = 0 afterwards.
- **Mid-frame stop:** set `frames_in` = 0 and assert `stop_in` at beat 3 of frame 1. Expect frame 1 to complete (8 beats), `frame_count_out` = 1 and `done_out` to pulse. Assert `stop_in` at beat 0 and expect an immediate end with `frame_count_out` unchanged.
- **Reset mid-run:** assert `rst` during LOAD after 5 writes. Expect every output at 0 the next cycle, no `done_out` pulse, and `start_in` accepted afterwards.
- **Readback (macro defined):** the memory model corrupts address 4 (bit 0 flipped). Expect `err_out` = 1 and `done_out` to pulse after N+1 VERIFY cycles, with no stream beats forwarded. With a clean memory, expect RUN to be entered.
- **Ignored control:** assert `start_in` during RUN. Expect no restart and no change to `frame_count_out`.
